ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RSA-decryption ASIP pipeline, consuming the ID/EX register outputs and producing the values latched by the EX/MEM register. Performs single-cycle addition or multi-cycle interleaved modular multiplication (the RSA kernel) on operands resolved through MEM/WB forwarding. While a multiplication is in progress it asserts `stall` to freeze IF/ID/ID-EX and presents bubbles downstream.

## Interface
- N, 32, datapath width
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- rda_ex, rdb_ex, extended_ex  in  N  register operands and extended immediate from ID/EX
- ra_ex, rb_ex, rw_ex  in  5  source/destination register numbers
- wr_en_ex, opb_selector_ex, alu_func_ex, wd_selector_ex, wm_ex  in  1  controls from ID/EX
- modulus  in  N  RSA modulus M, held stable while busy
- rw_mem, rw_wb  in  5  destination of the instruction in MEM / WB
- wr_en_mem, wr_en_wb  in  1  register-write enables of MEM / WB
- result_mem, result_wb  in  N  forwarding values from MEM / WB
- alu_result  out  N  add sum or modular product
- store_data  out  N  forwarded operand B register value (for stores)
- rw_out  out  5  passthrough of rw_ex
- wr_en_out, wd_selector_out, wm_out  out  1  controls to EX/MEM
- stall  out  1  freeze upstream stages

## Operation
- Forwarding per source: if wr_en_mem && rw_mem==ra_ex && ra_ex!=0 use result_mem; else if wr_en_wb && rw_wb==ra_ex && ra_ex!=0 use result_wb; else rda_ex. Same for B with rb_ex/rdb_ex. MEM has priority; r0 never forwarded.
- opb_selector_ex: 0 → forwarded B, 1 → extended_ex. store_data is always forwarded B.
- alu_func_ex 0 (ADD): alu_result = A + B mod 2^N, combinational; controls pass through; stall=0.
- alu_func_ex 1 (MODMUL): result = (A·B) mod M via interleaved shift-add, MSB first: P←2P; if A[i] P←P+B; up to two conditional subtractions of M. Internal P width N+2. Precondition A,B < M; otherwise result unspecified. M==0 → result 0 at same latency.
- FSM states IDLE, MUL, DONE:
  - IDLE: alu_func_ex=1 → capture forwarded A, B(after opb select), clear P, counter=N-1, go MUL; stall=1, bubble out.
  - MUL: one iteration per cycle; counter decrements; at counter 0 go DONE; stall=1, bubble out.
  - DONE: alu_result=P; controls pass through; stall=0; go IDLE.
- Bubble: wr_en_out=0, wm_out=0, wd_selector_out=0, alu_result=0.

## Timing
- ADD: 0-cycle latency, one instruction per cycle.
- MODMUL: occupies EX N+2 cycles (1 IDLE capture + N MUL + 1 DONE); stall high for exactly N+1 cycles, result valid in DONE cycle only. ID/EX held stable by stall; operands captured at IDLE so MEM/WB draining during stall is harmless.
- DONE→IDLE coincides with ID/EX advance; the next instruction, even another MODMUL, starts in the following cycle.
- Reset (any state, including mid-MUL): next cycle state=IDLE, P=0, counter=0. While reset high: stall=0, all control outputs 0, alu_result=0, store_data=0, rw_out=0.
- modulus sampled every MUL cycle; changing it while busy is unsupported.

## Structure
- asip_pkg: ex_state_t enum {IDLE, MUL, DONE}; ALU_ADD=1'b0, ALU_MODMUL=1'b1; OPB_REG=1'b0, OPB_IMM=1'b1.
- Sub-module mod_mul_iter: start/busy/done handshake, operands, modulus, product; contains P, counter, FSM. ex_stage keeps forwarding, operand muxing, adder, output muxing.

## Test plan
- ADD reg: rda=5, rdb=7, opb_sel=0, alu_func=0 → alu_result=12, stall=0, wr_en_out=wr_en_ex same cycle.
- ADD imm wrap: rda=0xFFFFFFFF, extended=1, opb_sel=1 → alu_result=0.
- MODMUL: modulus=3233, A=B=65 → stall high 33 cycles, alu_result=992 in cycle 34 only, wr_en_out=0 in cycles 1-33; back-to-back second MODMUL (A=992,B=65, 992·65 mod 3233 = 3053) starts next cycle.
- Forwarding: ra_ex=3, rda=1, rw_mem=3/wr_en_mem=1/result_mem=100, rw_wb=3/result_wb=200 → A=100; MEM disabled → 200; ra_ex=0 → rda used.
- Reset at MUL cycle 10 → next cycle stall=0, outputs 0; subsequent ADD 2+3=5 correct.
- modulus=0, A=7, B=9 → result 0 after N+2 cycles.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared types and helpers for the RSA-decryption ASIP execute stage.
// The modmul step is a single MSB-first shift-add-reduce iteration.
package asip_pkg;

  localparam int XLEN  = 32;
  localparam int P_W   = XLEN + 2;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  localparam logic ALU_ADD    = 1'b0;
  localparam logic ALU_MODMUL = 1'b1;
  localparam logic OPB_REG    = 1'b0;
  localparam logic OPB_IMM    = 1'b1;

  // P <- 2P (+B); then at most two subtractions bring it back below M.
  function automatic logic [P_W-1:0] modmul_step(input logic [P_W-1:0]  p,
                                                 input logic             a_bit,
                                                 input logic [XLEN-1:0]  b,
                                                 input logic [XLEN-1:0]  m);
    logic [P_W-1:0] t;
    logic [P_W-1:0] mm;
    mm = {2'b00, m};
    t  = (p << 1) + (a_bit ? {2'b00, b} : {P_W{1'b0}});
    if (t >= mm) begin
      t = t - mm;
    end else begin
      t = t;
    end
    if (t >= mm) begin
      t = t - mm;
    end else begin
      t = t;
    end
    if (m == {XLEN{1'b0}}) begin
      t = {P_W{1'b0}};
    end else begin
      t = t;
    end
    return t;
  endfunction

endpackage

// File: rtl/mod_mul_iter.sv
// Iterative interleaved modular multiplier: one operand bit per cycle,
// with a start/busy/done handshake toward the execute stage.
module mod_mul_iter
  import asip_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] modulus_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);

  ex_state_t        state_q, state_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;

  // State, partial product, bit counter and captured operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= {P_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {XLEN{1'b0}};
      b_q     <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic; operands are latched at start so forwarding sources may drain.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          p_d     = {P_W{1'b0}};
          cnt_d   = CNT_INIT;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        p_d = modmul_step(p_q, a_q[cnt_q], b_q, modulus_i);
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q == MUL) || ((state_q == IDLE) && start_i);
  assign done_o    = (state_q == DONE);
  assign product_o = p_q[XLEN-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: MEM/WB forwarding, operand B select, single-cycle add and
// multi-cycle modular multiply with upstream stall and downstream bubbles.
module ex_stage
  import asip_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] rda_ex,
  input  logic [XLEN-1:0] rdb_ex,
  input  logic [XLEN-1:0] extended_ex,
  input  logic [4:0]      ra_ex,
  input  logic [4:0]      rb_ex,
  input  logic [4:0]      rw_ex,
  input  logic            wr_en_ex,
  input  logic            opb_selector_ex,
  input  logic            alu_func_ex,
  input  logic            wd_selector_ex,
  input  logic            wm_ex,
  input  logic [XLEN-1:0] modulus,
  input  logic [4:0]      rw_mem,
  input  logic [4:0]      rw_wb,
  input  logic            wr_en_mem,
  input  logic            wr_en_wb,
  input  logic [XLEN-1:0] result_mem,
  input  logic [XLEN-1:0] result_wb,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rw_out,
  output logic            wr_en_out,
  output logic            wd_selector_out,
  output logic            wm_out,
  output logic            stall
);

  logic [XLEN-1:0] fwd_a_s, fwd_b_s, opb_s, sum_s, product_s;
  logic            mul_start_s, mul_busy_s, mul_done_s;

  // Operand forwarding: MEM beats WB, register r0 is never forwarded.
  always_comb begin
    fwd_a_s = rda_ex;
    fwd_b_s = rdb_ex;
    if (wr_en_mem && (rw_mem == ra_ex) && (ra_ex != 5'd0)) begin
      fwd_a_s = result_mem;
    end else if (wr_en_wb && (rw_wb == ra_ex) && (ra_ex != 5'd0)) begin
      fwd_a_s = result_wb;
    end else begin
      fwd_a_s = rda_ex;
    end
    if (wr_en_mem && (rw_mem == rb_ex) && (rb_ex != 5'd0)) begin
      fwd_b_s = result_mem;
    end else if (wr_en_wb && (rw_wb == rb_ex) && (rb_ex != 5'd0)) begin
      fwd_b_s = result_wb;
    end else begin
      fwd_b_s = rdb_ex;
    end
  end

  assign opb_s       = (opb_selector_ex == OPB_IMM) ? extended_ex : fwd_b_s;
  assign sum_s       = fwd_a_s + opb_s;
  assign mul_start_s = (alu_func_ex == ALU_MODMUL);

  mod_mul_iter u_mod_mul (
    .clock     (clock),
    .reset     (reset),
    .start_i   (mul_start_s),
    .a_i       (fwd_a_s),
    .b_i       (opb_s),
    .modulus_i (modulus),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (product_s)
  );

  // Output select: zeros in reset, bubble while multiplying, else pass through.
  always_comb begin
    alu_result      = {XLEN{1'b0}};
    store_data      = {XLEN{1'b0}};
    rw_out          = 5'd0;
    wr_en_out       = 1'b0;
    wd_selector_out = 1'b0;
    wm_out          = 1'b0;
    stall           = 1'b0;
    if (reset) begin
      stall = 1'b0;
    end else begin
      store_data = fwd_b_s;
      rw_out     = rw_ex;
      if (mul_busy_s) begin
        stall = 1'b1;
      end else begin
        alu_result      = mul_done_s ? product_s : sum_s;
        wr_en_out       = wr_en_ex;
        wd_selector_out = wd_selector_ex;
        wm_out          = wm_ex;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: cycle-level reference model plus literal checks.
module tb_ex_stage;

  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rda_ex, rdb_ex, extended_ex, modulus, result_mem, result_wb;
  logic [4:0]  ra_ex, rb_ex, rw_ex, rw_mem, rw_wb;
  logic        wr_en_ex, opb_selector_ex, alu_func_ex, wd_selector_ex, wm_ex;
  logic        wr_en_mem, wr_en_wb;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rw_out;
  logic        wr_en_out, wd_selector_out, wm_out, stall;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: m_cnt 0 = idle, 1..N = multiplying, N+1 = result cycle
  int          m_cnt = 0;
  logic [31:0] m_prod = 32'd0;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock(clock), .reset(reset),
    .rda_ex(rda_ex), .rdb_ex(rdb_ex), .extended_ex(extended_ex),
    .ra_ex(ra_ex), .rb_ex(rb_ex), .rw_ex(rw_ex),
    .wr_en_ex(wr_en_ex), .opb_selector_ex(opb_selector_ex), .alu_func_ex(alu_func_ex),
    .wd_selector_ex(wd_selector_ex), .wm_ex(wm_ex), .modulus(modulus),
    .rw_mem(rw_mem), .rw_wb(rw_wb), .wr_en_mem(wr_en_mem), .wr_en_wb(wr_en_wb),
    .result_mem(result_mem), .result_wb(result_wb),
    .alu_result(alu_result), .store_data(store_data), .rw_out(rw_out),
    .wr_en_out(wr_en_out), .wd_selector_out(wd_selector_out), .wm_out(wm_out),
    .stall(stall)
  );

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rd);
    if (wr_en_mem && rw_mem == r && r != 5'd0) return result_mem;
    if (wr_en_wb && rw_wb == r && r != 5'd0) return result_wb;
    return rd;
  endfunction

  function automatic logic [31:0] opb();
    return opb_selector_ex ? extended_ex : fwd(rb_ex, rdb_ex);
  endfunction

  function automatic logic [31:0] ref_modmul(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] m);
    longint unsigned prod;
    if (m == 32'd0) return 32'd0;
    prod = (longint'(a) * longint'(b)) % longint'(m);
    return prod[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (alu_func_ex) begin
        m_cnt  <= 1;
        m_prod <= ref_modmul(fwd(ra_ex, rda_ex), opb(), modulus);
      end
    end else if (m_cnt == N + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clock) begin
    logic        e_stall;
    logic [31:0] e_alu;
    if (chk_en) begin
      if (reset) begin
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_alu", alu_result, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_rw", {27'd0, rw_out}, 32'd0);
        check("rst_ctl", {29'd0, wr_en_out, wd_selector_out, wm_out}, 32'd0);
      end else begin
        e_stall = (m_cnt == 0 && alu_func_ex) || (m_cnt >= 1 && m_cnt <= N);
        e_alu   = e_stall ? 32'd0 : (m_cnt == N + 1) ? m_prod : fwd(ra_ex, rda_ex) + opb();
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("alu_result", alu_result, e_alu);
        check("store_data", store_data, fwd(rb_ex, rdb_ex));
        check("rw_out", {27'd0, rw_out}, {27'd0, rw_ex});
        check("ctl", {29'd0, wr_en_out, wd_selector_out, wm_out},
              e_stall ? 32'd0 : {29'd0, wr_en_ex, wd_selector_ex, wm_ex});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic [4:0] ra, input logic [31:0] rda, input logic [4:0] rb,
                        input logic [31:0] rdb, input logic [31:0] ext, input logic sel,
                        input logic func, input logic [4:0] rw, input logic we);
    ra_ex = ra; rda_ex = rda; rb_ex = rb; rdb_ex = rdb; extended_ex = ext;
    opb_selector_ex = sel; alu_func_ex = func; rw_ex = rw; wr_en_ex = we;
    wd_selector_ex = 1'b1; wm_ex = 1'b0;
  endtask

  task automatic run_mul(input string name, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clock);
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    check({name, "_stall_cycles"}, 32'(n), 32'd33);
    check(name, alu_result, exp);
    check({name, "_wr_en"}, {31'd0, wr_en_out}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    modulus = 32'd3233;
    rw_mem = 5'd0; rw_wb = 5'd0; wr_en_mem = 1'b0; wr_en_wb = 1'b0;
    result_mem = 32'd0; result_wb = 32'd0;
    set_id(5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    step();
    chk_en = 1'b1;
    step();
    @(negedge clock);
    check("lit_reset_stall", {31'd0, stall}, 32'd0);
    check("lit_reset_alu", alu_result, 32'd0);
    step();
    reset = 1'b0;

    set_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    @(negedge clock);
    check("lit_add_reg", alu_result, 32'd12);
    check("lit_add_wr_en", {31'd0, wr_en_out}, 32'd1);
    step();
    set_id(5'd1, 32'hFFFF_FFFF, 5'd2, 32'd0, 32'd1, 1'b1, 1'b0, 5'd5, 1'b1);
    @(negedge clock);
    check("lit_add_wrap", alu_result, 32'd0);
    step();

    set_id(5'd3, 32'd1, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd6, 1'b1);
    rw_mem = 5'd3; wr_en_mem = 1'b1; result_mem = 32'd100;
    rw_wb = 5'd3; wr_en_wb = 1'b1; result_wb = 32'd200;
    @(negedge clock);
    check("lit_fwd_mem", alu_result, 32'd100);
    step();
    wr_en_mem = 1'b0;
    @(negedge clock);
    check("lit_fwd_wb", alu_result, 32'd200);
    step();
    ra_ex = 5'd0;
    @(negedge clock);
    check("lit_fwd_r0", alu_result, 32'd1);
    step();
    wr_en_wb = 1'b0;

    set_id(5'd1, 32'd65, 5'd2, 32'd65, 32'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    run_mul("lit_modmul1", 32'd992);
    step();
    set_id(5'd1, 32'd992, 5'd2, 32'd65, 32'd0, 1'b0, 1'b1, 5'd8, 1'b1);
    run_mul("lit_modmul2", 32'd3053);
    step();

    set_id(5'd1, 32'd100, 5'd2, 32'd200, 32'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    repeat (10) step();
    reset = 1'b1;
    @(negedge clock);
    check("lit_midreset_stall", {31'd0, stall}, 32'd0);
    check("lit_midreset_alu", alu_result, 32'd0);
    check("lit_midreset_store", store_data, 32'd0);
    step();
    reset = 1'b0;
    set_id(5'd1, 32'd2, 5'd2, 32'd3, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1);
    @(negedge clock);
    check("lit_post_reset_add", alu_result, 32'd5);
    check("lit_post_reset_stall", {31'd0, stall}, 32'd0);
    step();

    modulus = 32'd0;
    set_id(5'd1, 32'd7, 5'd2, 32'd9, 32'd0, 1'b0, 1'b1, 5'd11, 1'b1);
    run_mul("lit_modmul_m0", 32'd0);
    step();
    set_id(5'd1, 32'd40, 5'd2, 32'd2, 32'd0, 1'b0, 1'b0, 5'd12, 1'b0);
    @(negedge clock);
    check("lit_final_add", alu_result, 32'd42);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
